// File: rtl/pi_sched.sv
`default_nettype none
// ============================================================================
// Module   : pi_sched
// Purpose  : KS10 priority-interrupt scheduler; arbitrates seven levels and
//            hands one at a time to the microcode via a req/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
module pi_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        clken,
  input  logic [0:35] dp,
  input  logic        piLOAD,
  input  logic [1:7]  aprINTR,
  input  logic [1:7]  uba0INTR,
  input  logic [1:7]  uba1INTR,
  input  logic        piACK,
  input  logic        piDISMISS,
  output logic        piREQ,
  output logic [0:2]  piLEVEL,
  output logic [0:35] piSTATUS
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_on;
  logic [1:7] r_en;
  logic [1:7] r_prog;
  logic [1:7] r_act;
  logic [0:2] r_lvl;
  logic       r_req;

  logic       w_clrAll;
  logic       w_abort;
  logic [1:7] w_sel;
  logic [1:7] w_ext;
  logic       w_on;
  logic [1:7] w_en;
  logic [1:7] w_prog;
  logic [1:7] w_dis;
  logic [1:7] w_ack;
  logic       w_masked;
  logic [0:2] w_win;
  logic       w_unused;

  assign w_clrAll = piLOAD & dp[22];
  assign w_sel    = dp[29:35];
  assign w_ext    = aprINTR | uba0INTR | uba1INTR;
  // A pending request is withdrawn whenever the system ends this cycle off.
  assign w_abort  = w_clrAll | ~w_on;
  assign w_unused = ^dp[0:21];

  // Control-word bits take effect in ascending dp order.
  always_comb begin
    w_on   = r_on;
    w_en   = r_en;
    w_prog = r_prog;
    if (piLOAD) begin
      if (dp[22]) begin
        w_on   = 1'b0;
        w_en   = '0;
        w_prog = '0;
      end
      if (dp[23]) w_prog = w_prog & ~w_sel;
      if (dp[24]) w_prog = w_prog | w_sel;
      if (dp[25]) w_en   = w_en | w_sel;
      if (dp[26]) w_en   = w_en & ~w_sel;
      if (dp[27]) w_on   = 1'b0;
      if (dp[28]) w_on   = 1'b1;
    end
  end

  // Dismiss works on the pre-ack image; the ack bit is OR-ed in afterwards.
  always_comb begin
    w_dis = '0;
    w_ack = '0;
    if (piDISMISS) begin
      for (int n = 7; n >= 1; n--) begin
        if (r_act[n]) begin
          w_dis    = '0;
          w_dis[n] = 1'b1;
        end
      end
    end
    if (r_state == REQ && piACK && !w_abort) begin
      for (int n = 1; n <= 7; n++) begin
        if (r_lvl == 3'(n)) w_ack[n] = 1'b1;
      end
    end
  end

  always_comb begin
    w_masked = 1'b0;
    w_win    = '0;
    for (int n = 1; n <= 7; n++) begin
      w_masked = w_masked | r_act[n];
      if (w_win == 3'd0 && !w_masked && r_on && ((r_en[n] && w_ext[n]) || r_prog[n]))
        w_win = 3'(n);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_on    <= 1'b0;
      r_en    <= '0;
      r_prog  <= '0;
      r_act   <= '0;
      r_lvl   <= '0;
      r_req   <= 1'b0;
    end else if (clken) begin
      r_on   <= w_on;
      r_en   <= w_en;
      r_prog <= w_prog;
      r_act  <= w_clrAll ? 7'b0 : ((r_act & ~w_dis) | w_ack);
      case (r_state)
        IDLE: begin
          if (w_win != 3'd0 && !w_clrAll) begin
            r_state <= REQ;
            r_req   <= 1'b1;
            r_lvl   <= w_win;
          end
        end
        REQ: begin
          if (w_abort) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_lvl   <= '0;
          end else if (piACK) begin
            r_state <= SETTLE;
            r_req   <= 1'b0;
            r_lvl   <= '0;
          end
        end
        SETTLE:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign piREQ   = r_req;
  assign piLEVEL = r_lvl;

  always_comb begin
    piSTATUS        = '0;
    piSTATUS[11:17] = r_prog;
    piSTATUS[21:27] = r_act;
    piSTATUS[28]    = r_on;
    piSTATUS[29:35] = r_en;
  end

endmodule
`default_nettype wire

// File: tb/tb_pi_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_pi_sched
// Purpose  : Directed self-checking bench for pi_sched with a level-based
//            reference model of the interrupt system.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pi_sched;

  localparam logic [22:28] OP_CLR  = 7'b1000000;
  localparam logic [22:28] OP_PCLR = 7'b0100000;
  localparam logic [22:28] OP_PSET = 7'b0010000;
  localparam logic [22:28] OP_ESET = 7'b0001000;
  localparam logic [22:28] OP_ON   = 7'b0000001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clken = 1'b1;
  logic [0:35] dp = '0;
  logic        piLOAD = 1'b0;
  logic [1:7]  aprINTR = '0;
  logic [1:7]  uba0INTR = '0;
  logic [1:7]  uba1INTR = '0;
  logic        piACK = 1'b0;
  logic        piDISMISS = 1'b0;
  logic        piREQ;
  logic [0:2]  piLEVEL;
  logic [0:35] piSTATUS;

  int checks = 0;
  int errors = 0;

  // Model: channel arrays, plus the level being offered and a cool-down flag.
  bit mOn;
  bit mEn[1:7];
  bit mProg[1:7];
  bit mAct[1:7];
  int mPend;
  bit mCool;

  pi_sched dut (
    .clk(clk), .rst(rst), .clken(clken), .dp(dp), .piLOAD(piLOAD),
    .aprINTR(aprINTR), .uba0INTR(uba0INTR), .uba1INTR(uba1INTR),
    .piACK(piACK), .piDISMISS(piDISMISS),
    .piREQ(piREQ), .piLEVEL(piLEVEL), .piSTATUS(piSTATUS)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mOn = 0; mPend = 0; mCool = 0;
    for (int n = 1; n <= 7; n++) begin
      mEn[n] = 0; mProg[n] = 0; mAct[n] = 0;
    end
  endtask

  function automatic logic [35:0] modelStatus();
    logic [0:35] s;
    s = '0;
    for (int n = 1; n <= 7; n++) begin
      s[10 + n] = mProg[n];
      s[20 + n] = mAct[n];
      s[28 + n] = mEn[n];
    end
    s[28] = mOn;
    return s;
  endfunction

  task automatic modelStep();
    int  win;
    bit  blocked, clr, nOn, done;
    bit  nEn[1:7];
    bit  nProg[1:7];
    bit  nAct[1:7];
    if (!clken) return;
    win = 0; blocked = 0;
    for (int n = 1; n <= 7; n++) begin
      if (mAct[n]) blocked = 1;
      if (win == 0 && !blocked && mOn &&
          ((mEn[n] && (aprINTR[n] || uba0INTR[n] || uba1INTR[n])) || mProg[n]))
        win = n;
    end
    clr = piLOAD && dp[22];
    nOn = mOn; nEn = mEn; nProg = mProg; nAct = mAct;
    if (piLOAD) begin
      if (dp[22]) begin
        nOn = 0;
        for (int n = 1; n <= 7; n++) begin nEn[n] = 0; nProg[n] = 0; end
      end
      for (int n = 1; n <= 7; n++) begin
        if (dp[28 + n]) begin
          if (dp[23]) nProg[n] = 0;
          if (dp[24]) nProg[n] = 1;
          if (dp[25]) nEn[n] = 1;
          if (dp[26]) nEn[n] = 0;
        end
      end
      if (dp[27]) nOn = 0;
      if (dp[28]) nOn = 1;
    end
    done = 0;
    if (piDISMISS) begin
      for (int n = 1; n <= 7; n++) begin
        if (!done && mAct[n]) begin nAct[n] = 0; done = 1; end
      end
    end
    if (mPend != 0) begin
      if (clr || !nOn) mPend = 0;
      else if (piACK) begin nAct[mPend] = 1; mPend = 0; mCool = 1; end
    end else if (mCool) begin
      mCool = 0;
    end else if (win != 0 && !clr) begin
      mPend = win;
    end
    if (clr) for (int n = 1; n <= 7; n++) nAct[n] = 0;
    mOn = nOn; mEn = nEn; mProg = nProg; mAct = nAct;
  endtask

  // One clock: advance the model, let the edge happen, compare all outputs.
  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    chk("piREQ", 36'(piREQ), 36'(mPend != 0));
    chk("piLEVEL", 36'(piLEVEL), 36'(mPend));
    chk("piSTATUS", 36'(piSTATUS), modelStatus());
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic load(input logic [22:28] op, input logic [1:7] sel);
    dp = '0;
    dp[22:28] = op;
    dp[29:35] = sel;
    piLOAD = 1'b1;
    tick();
    piLOAD = 1'b0;
    dp = '0;
  endtask

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 36'(piREQ), 36'h0);
    chk("rst_level", 36'(piLEVEL), 36'h0);
    chk("rst_status", 36'(piSTATUS), 36'h0);
    rst = 1'b0;
    tick();

    // Basic request / ack / dismiss at level 5
    load(OP_ON | OP_ESET, 7'b0000100);
    chk("t1_status_on", 36'(piSTATUS), 36'h000000084);
    aprINTR = 7'b0000100;
    tick();
    chk("t1_req", 36'(piREQ), 36'h1);
    chk("t1_level", 36'(piLEVEL), 36'h5);
    piACK = 1'b1; tick(); piACK = 1'b0;
    chk("t1_act5", 36'(piSTATUS), 36'h000000484);
    chk("t1_req_low", 36'(piREQ), 36'h0);
    tick();
    chk("t1_req_low2", 36'(piREQ), 36'h0);
    tick();
    piDISMISS = 1'b1; tick(); piDISMISS = 1'b0;
    chk("t1_dismissed", 36'(piSTATUS), 36'h000000084);
    tick();
    chk("t1_rereq", 36'(piLEVEL), 36'h5);
    aprINTR = '0;
    load(OP_CLR, '0);
    ticks(2);

    // In-progress level 3 masks level 4 but not level 2
    load(OP_ON | OP_ESET, 7'h7F);
    load(OP_PSET, 7'b0010000);
    tick();
    chk("t2_prog3", 36'(piLEVEL), 36'h3);
    piACK = 1'b1; tick(); piACK = 1'b0;
    load(OP_PCLR, 7'b0010000);
    uba0INTR = 7'b0001000;
    ticks(3);
    chk("t2_masked4", 36'(piREQ), 36'h0);
    aprINTR = 7'b0100000;
    tick();
    chk("t2_level2", 36'(piLEVEL), 36'h2);
    uba0INTR = '0; aprINTR = '0;
    load(OP_CLR, '0);

    // No pre-emption of a pending level; clken low freezes everything
    load(OP_ON | OP_ESET, 7'h7F);
    aprINTR = 7'b0000010;
    tick();
    chk("t3_level6", 36'(piLEVEL), 36'h6);
    aprINTR = 7'b1000010;
    tick();
    chk("t3_hold6", 36'(piLEVEL), 36'h6);
    clken = 1'b0; piACK = 1'b1;
    ticks(2);
    chk("t3_frozen", 36'(piLEVEL), 36'h6);
    clken = 1'b1;
    tick(); piACK = 1'b0;
    chk("t3_ack_low", 36'(piREQ), 36'h0);
    tick();
    chk("t3_settle", 36'(piREQ), 36'h0);
    tick();
    chk("t3_level1", 36'(piLEVEL), 36'h1);
    aprINTR = '0;
    load(OP_CLR, '0);

    // Program request bypasses enables but needs the system on
    load(OP_ON | OP_PSET, 7'b0000001);
    tick();
    chk("t4_prog7", 36'(piLEVEL), 36'h7);
    load(OP_CLR, '0);
    load(OP_PSET, 7'b0000001);
    ticks(3);
    chk("t4_off", 36'(piREQ), 36'h0);
    load(OP_CLR, '0);

    // Same-cycle ack of level 4 and dismiss of level 6
    load(OP_ON | OP_ESET, 7'h7F);
    aprINTR = 7'b0000010;
    tick();
    piACK = 1'b1; tick(); piACK = 1'b0;
    aprINTR = 7'b0001000;
    ticks(2);
    chk("t5_level4", 36'(piLEVEL), 36'h4);
    piACK = 1'b1; piDISMISS = 1'b1;
    tick();
    piACK = 1'b0; piDISMISS = 1'b0;
    chk("t5_act4only", 36'(piSTATUS), 36'h0000008FF);
    piDISMISS = 1'b1;
    ticks(2);
    piDISMISS = 1'b0;
    chk("t5_noop", 36'(piSTATUS), 36'h0000000FF);
    aprINTR = '0;
    load(OP_CLR, '0);

    // Clear-all overrides an ack; async reset drops piREQ without an edge
    load(OP_ON | OP_ESET, 7'h7F);
    aprINTR = 7'b0010000;
    tick();
    dp = '0; dp[22] = 1'b1; piLOAD = 1'b1; piACK = 1'b1;
    tick();
    dp = '0; piLOAD = 1'b0; piACK = 1'b0;
    chk("t6_clr_status", 36'(piSTATUS), 36'h0);
    chk("t6_clr_req", 36'(piREQ), 36'h0);
    load(OP_ON | OP_ESET, 7'h7F);
    tick();
    chk("t6_req3", 36'(piREQ), 36'h1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_req", 36'(piREQ), 36'h0);
    chk("t6_async_lvl", 36'(piLEVEL), 36'h0);
    chk("t6_async_status", 36'(piSTATUS), 36'h0);
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    aprINTR = '0;
    ticks(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
